// File: rtl/hazard_pkg.sv
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared encodings and tag types for the pipeline hazard controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] WAIT_E = 2'd1;
   localparam logic [1:0] WAIT_M = 2'd2;
   localparam logic [1:0] WAIT_W = 2'd3;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [3:0] PC_REG = 4'd15;

   typedef struct packed {
      logic       valid;
      logic [3:0] wa;
      logic       ld;
      logic [3:0] ra1;
      logic [3:0] ra2;
   } tag_e_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] wa;
   } tag_wb_t;

   // Memory-stage producer wins over Writeback; the PC is never bypassed.
   function automatic logic [1:0] fwd_sel(input logic [3:0] rs, input tag_wb_t m,
                                          input tag_wb_t w, input logic [3:0] pc);
      if (rs == pc)                    return FWD_RF;
      else if (m.valid && m.wa == rs)  return FWD_M;
      else if (w.valid && w.wa == rs)  return FWD_W;
      else                             return FWD_RF;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_tag_pipe.sv
// ============================================================================
// Module  : hazard_tag_pipe
// Brief   : Shadow E/M/W destination-tag pipeline with bubble insertion and
//           condition-failed kill.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_tag_pipe
   import hazard_pkg::*;
(
   input  logic       CLK,
   input  logic       RESET,
   input  logic       flush_e,
   input  logic       regwrite_d,
   input  logic [3:0] wa3_d,
   input  logic       memtoreg_d,
   input  logic [3:0] ra1_d,
   input  logic [3:0] ra2_d,
   input  logic       cond_ex_e,
   output tag_e_t     tag_e,
   output tag_wb_t    tag_m,
   output tag_wb_t    tag_w
);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         tag_e <= '0;
         tag_m <= '0;
         tag_w <= '0;
      end else begin
         tag_e <= flush_e ? '0 : {regwrite_d, wa3_d, memtoreg_d, ra1_d, ra2_d};
         tag_m <= {tag_e.valid & cond_ex_e, tag_e.wa};
         tag_w <= tag_m;
      end
   end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module  : hazard_unit
// Brief   : Forwarding selects, load-use stall and PC-write branch FSM for the
//           5-stage core.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_unit
   import hazard_pkg::*;
#(
   parameter logic [3:0] PC_IDX = PC_REG
)(
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] RA1D,
   input  logic [3:0] RA2D,
   input  logic       UsesRA1D,
   input  logic       UsesRA2D,
   input  logic [3:0] WA3D,
   input  logic       RegWriteD,
   input  logic       MemtoRegD,
   input  logic       BranchD,
   input  logic       CondExE,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       BranchBusy
);

   tag_e_t     w_tag_e;
   tag_wb_t    w_tag_m;
   tag_wb_t    w_tag_w;
   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic       w_ldstall;
   logic       w_br_stall;
   logic       w_br_flush;

   hazard_tag_pipe u_tags (
      .CLK        (CLK),
      .RESET      (RESET),
      .flush_e    (FlushE),
      .regwrite_d (RegWriteD),
      .wa3_d      (WA3D),
      .memtoreg_d (MemtoRegD),
      .ra1_d      (RA1D),
      .ra2_d      (RA2D),
      .cond_ex_e  (CondExE),
      .tag_e      (w_tag_e),
      .tag_m      (w_tag_m),
      .tag_w      (w_tag_w)
   );

   assign ForwardAE = fwd_sel(w_tag_e.ra1, w_tag_m, w_tag_w, PC_IDX);
   assign ForwardBE = fwd_sel(w_tag_e.ra2, w_tag_m, w_tag_w, PC_IDX);

   // Qualified by IDLE so the D-stage bubble during a branch can never stall.
   assign w_ldstall = (r_state == IDLE) & w_tag_e.valid & w_tag_e.ld &
                      (w_tag_e.wa != PC_IDX) &
                      ((UsesRA1D & (RA1D == w_tag_e.wa)) |
                       (UsesRA2D & (RA2D == w_tag_e.wa)));

   always_comb begin
      w_state_nxt = r_state;
      w_br_stall  = 1'b0;
      w_br_flush  = 1'b0;
      case (r_state)
         IDLE: begin
            if (BranchD && !w_ldstall) begin
               w_state_nxt = WAIT_E;
               w_br_stall  = 1'b1;
               w_br_flush  = 1'b1;
            end
         end
         WAIT_E: begin
            if (CondExE) begin
               w_state_nxt = WAIT_M;
               w_br_stall  = 1'b1;
               w_br_flush  = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         WAIT_M: begin
            w_state_nxt = WAIT_W;
            w_br_stall  = 1'b1;
            w_br_flush  = 1'b1;
         end
         WAIT_W: begin
            w_state_nxt = IDLE;
            w_br_flush  = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   assign StallF     = w_ldstall | w_br_stall;
   assign StallD     = w_ldstall;
   assign FlushE     = w_ldstall;
   assign FlushD     = w_br_flush;
   assign BranchBusy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage ARM-subset core: sits beside the pipelined control path. It keeps its own shadow pipeline of destination-register tags (E/M/W) and drives operand forwarding selects for the Execute stage. It detects load-use hazards and stalls/bubbles around them. A small FSM holds fetch off while a PC-writing instruction (B, BL, BX) travels to Writeback.

## Interface
Parameters
- PC_IDX, default 15: register index never forwarded or hazard-checked (PC).

Ports
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high.
- RA1D, RA2D  in  4 each  source register indices of the Decode-stage instruction.
- UsesRA1D, UsesRA2D  in  1 each  the Decode instruction actually reads RA1D / RA2D.
- WA3D  in  4  destination index of the Decode instruction.
- RegWriteD, MemtoRegD  in  1 each  Decode instruction writes a register / is a load.
- BranchD  in  1  Decode instruction writes PC (PCSrcD).
- CondExE  in  1  condition passed for the Execute instruction.
- StallF, StallD  out  1 each  hold PC / hold the F->D register.
- FlushD, FlushE  out  1 each  load a bubble into the D / E register at next edge.
- ForwardAE, ForwardBE  out  2 each  Execute operand A/B select: 00 register file, 01 ResultW, 10 ALUOutM.
- BranchBusy  out  1  FSM not IDLE.

## Operation
- Tag pipeline: TagE = {valid, wa, ld, ra1, ra2}, TagM = {valid, wa}, TagW = {valid, wa}.
  - Each edge: TagE <= FlushE ? bubble : {RegWriteD, WA3D, MemtoRegD, RA1D, RA2D}.
  - TagM <= {TagE.valid & CondExE, TagE.wa}.
  - TagW <= TagM.
  - A bubble has all fields zero.
- Forwarding (combinational from tags), per operand, with rs = TagE.ra1 for A and TagE.ra2 for B:
  - 10 if TagM.valid, TagM.wa == rs, rs != PC_IDX.
  - else 01 if TagW.valid, TagW.wa == rs, rs != PC_IDX.
  - else 00.
  - M beats W when both match.
- Load-use (ldstall):
  - Condition: TagE.valid & TagE.ld & TagE.wa != PC_IDX & ((UsesRA1D & RA1D == TagE.wa) | (UsesRA2D & RA2D == TagE.wa)).
  - Action: StallF = StallD = FlushE = 1.
- Branch FSM states: IDLE, WAIT_E, WAIT_M, WAIT_W.
  - IDLE: BranchD & !ldstall -> WAIT_E, asserting StallF = FlushD = 1 that cycle. With ldstall, the branch waits in D and is not accepted.
  - WAIT_E, CondExE = 0 (not taken) -> IDLE; StallF = FlushD = 0, so the held sequential fetch proceeds.
  - WAIT_E, CondExE = 1 -> WAIT_M; StallF = FlushD = 1.
  - WAIT_M -> WAIT_W; StallF = FlushD = 1.
  - WAIT_W -> IDLE; StallF = 0 (PC loads target from W), FlushD = 1.
- Priority: ldstall and the FSM are mutually exclusive, because the FSM leaves IDLE only when ldstall = 0. In WAIT_* states StallD = 0 and FlushE = 0; ldstall cannot arise because D holds a bubble.
- BranchD while not IDLE is ignored (D is flushed).

## Timing
- Reset values: all outputs 0, FSM IDLE, all tags invalid/zero.
- Forward and stall outputs are combinational from registered tags plus D inputs, in the same cycle.
- A load-use costs exactly 1 bubble.
- A taken branch costs 4 fetch cycles: branch in D, plus WAIT_E/M/W.
- A not-taken conditional branch costs 2 fetch cycles.
- RESET mid-branch: FSM returns to IDLE and tags clear at that edge; no flush/stall persists.
- PC_IDX destinations never forward. BL writing R14 forwards normally.

## Structure
- Shared package hazard_pkg holds:
  - state enum: IDLE = 0, WAIT_E = 1, WAIT_M = 2, WAIT_W = 3.
  - forward encodings: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - PC register index constant.
- One sub-module, hazard_tag_pipe: the E/M/W tag registers with FlushE bubble insertion and CondExE kill. FSM and compare logic stay in the top.

## Test plan
- ADD R1 at D, then SUB R2 = R1 - R3 next cycle -> ForwardAE = 10 while SUB is in E. One cycle later, an instruction reading R1 in E -> ForwardAE = 01.
- LDR R4, then ADD R5, R4, R4 immediately -> one cycle StallF = StallD = FlushE = 1; ADD in E next cycle gets ForwardAE = ForwardBE = 01.
- B (taken, AL) enters D -> StallF = 1 for 3 cycles, FlushD = 1 for 4 cycles, BranchBusy = 1 for 3 cycles, then IDLE.
- BEQ with Z = 0 (CondExE = 0) -> FSM IDLE -> WAIT_E -> IDLE; StallF high exactly 1 cycle.
- Conditional ADD R1 failing (CondExE = 0), then a reader of R1 -> ForwardAE = 00. Writes to R15 are never forwarded.
- RESET asserted during WAIT_M -> next cycle all outputs 0, BranchBusy = 0, tags invalid.
